// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
//   Owns the shared multiplexed RTC bus and arbitrates it between the periodic
//   read sequencer and the write sequencer. Generates the refresh trigger,
//   issues one-cycle start pulses, muxes the granted engine onto the pins,
//   inserts idle guard cycles after each transaction and releases the bus via
//   a watchdog if an engine never reports done.
//
// Ports
//   clock, reset           : system clock, asynchronous active-low reset
//   rfsh_en                : enables the refresh timer
//   wr_req / wr_ack        : level write request / end-of-write pulse
//   rd_start / rd_done     : read sequencer handshake
//   wr_start / wr_done     : write sequencer handshake
//   rd_* / wr_*            : engine bus controls and address/data
//   bus_*                  : RTC pins (idle: controls 1, AD 8'hFF)
//   grant                  : one-hot owner (01 read, 10 write, 00 none)
//   busy                   : high outside IDLE
//   timeout_err            : sticky watchdog release flag
module rtc_bus_arbiter #(
    parameter int unsigned REFRESH_CYCLES = 10000000,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned GUARD_CYCLES   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rfsh_en,
    input  logic       wr_req,
    output logic       wr_ack,
    output logic       rd_start,
    input  logic       rd_done,
    output logic       wr_start,
    input  logic       wr_done,
    input  logic       rd_ad,
    input  logic       rd_wr,
    input  logic       rd_rd,
    input  logic       rd_cs,
    input  logic [7:0] rd_adout,
    input  logic       wr_ad,
    input  logic       wr_wr,
    input  logic       wr_rd,
    input  logic       wr_cs,
    input  logic [7:0] wr_adout,
    output logic       bus_ad,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic       bus_cs,
    output logic [7:0] bus_adout,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned TW = $clog2(REFRESH_CYCLES);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_BUSY,
        S_WR_ISSUE,
        S_WR_BUSY,
        S_GUARD
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [WW-1:0] wd_q;
    logic [GW-1:0] guard_q;
    logic [1:0]    grant_q, grant_d;
    logic          rd_pend_q, rd_pend_d;
    logic          last_wr_q, last_wr_d;   // 1: last owner was the write engine
    logic          tmo_q, tmo_d;
    logic          tick;
    logic          wd_exp;
    logic          guard_end;
    logic          rd_req;

    assign tick      = rfsh_en && (timer_q == TW'(REFRESH_CYCLES - 1));
    assign wd_exp    = (wd_q == WW'(TIMEOUT_CYCLES - 1));
    assign guard_end = (guard_q == GW'(GUARD_CYCLES - 1));
    // A tick landing in IDLE competes in the same cycle as a pending read.
    assign rd_req    = rd_pend_q | tick;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            wd_q      <= '0;
            guard_q   <= '0;
            grant_q   <= '0;
            rd_pend_q <= 1'b0;
            last_wr_q <= 1'b1;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rd_pend_q <= rd_pend_d;
            last_wr_q <= last_wr_d;
            tmo_q     <= tmo_d;

            if (!rfsh_en || tick) timer_q <= '0;
            else                  timer_q <= timer_q + 1'b1;

            if (state_q == S_RD_BUSY || state_q == S_WR_BUSY) wd_q <= wd_q + 1'b1;
            else                                              wd_q <= '0;

            if (state_q == S_GUARD) guard_q <= guard_q + 1'b1;
            else                    guard_q <= '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rd_pend_d = rd_pend_q | tick;
        last_wr_d = last_wr_q;
        tmo_d     = tmo_q;
        rd_start  = 1'b0;
        wr_start  = 1'b0;
        wr_ack    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_req && (!wr_req || last_wr_q)) begin
                    state_d = S_RD_ISSUE;
                    grant_d = 2'b01;
                end else if (wr_req) begin
                    state_d = S_WR_ISSUE;
                    grant_d = 2'b10;
                end
            end
            S_RD_ISSUE: begin
                rd_start  = 1'b1;
                rd_pend_d = tick;
                last_wr_d = 1'b0;
                state_d   = S_RD_BUSY;
            end
            S_RD_BUSY: begin
                if (rd_done || wd_exp) begin
                    state_d = S_GUARD;
                    grant_d = 2'b00;
                    if (!rd_done) tmo_d = 1'b1;
                end
            end
            S_WR_ISSUE: begin
                wr_start  = 1'b1;
                last_wr_d = 1'b1;
                state_d   = S_WR_BUSY;
            end
            S_WR_BUSY: begin
                if (wr_done || wd_exp) begin
                    state_d = S_GUARD;
                    grant_d = 2'b00;
                    wr_ack  = 1'b1;
                    if (!wr_done) tmo_d = 1'b1;
                end
            end
            S_GUARD: begin
                if (guard_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_comb begin
        bus_ad    = 1'b1;
        bus_wr    = 1'b1;
        bus_rd    = 1'b1;
        bus_cs    = 1'b1;
        bus_adout = 8'hFF;
        if (grant_q == 2'b01) begin
            bus_ad    = rd_ad;
            bus_wr    = rd_wr;
            bus_rd    = rd_rd;
            bus_cs    = rd_cs;
            bus_adout = rd_adout;
        end else if (grant_q == 2'b10) begin
            bus_ad    = wr_ad;
            bus_wr    = wr_wr;
            bus_rd    = wr_rd;
            bus_cs    = wr_cs;
            bus_adout = wr_adout;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
module tb_rtc_bus_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // shared engine bus inputs
    logic       rd_ad = 1'b0, rd_wr = 1'b1, rd_rd = 1'b0, rd_cs = 1'b0;
    logic [7:0] rd_adout = 8'h5A;
    logic       wr_ad = 1'b1, wr_wr = 1'b0, wr_rd = 1'b1, wr_cs = 1'b0;
    logic [7:0] wr_adout = 8'hC3;

    // instance A: REFRESH=100 TIMEOUT=50 GUARD=4
    logic       reset_a = 1'b0, rfsh_en_a = 1'b0, wr_req_a = 1'b0, rd_done_a = 1'b0, wr_done_a = 1'b0;
    logic       wr_ack_a, rd_start_a, wr_start_a, busy_a, tmo_a;
    logic       bad_a, bwr_a, brd_a, bcs_a;
    logic [7:0] bout_a;
    logic [1:0] grant_a;

    // instance B: REFRESH=100 TIMEOUT=300 GUARD=4
    logic       reset_b = 1'b0, rfsh_en_b = 1'b0, wr_req_b = 1'b0, rd_done_b = 1'b0, wr_done_b = 1'b0;
    logic       wr_ack_b, rd_start_b, wr_start_b, busy_b, tmo_b;
    logic       bad_b, bwr_b, brd_b, bcs_b;
    logic [7:0] bout_b;
    logic [1:0] grant_b;

    rtc_bus_arbiter #(.REFRESH_CYCLES(100), .TIMEOUT_CYCLES(50), .GUARD_CYCLES(4)) u_a (
        .clock(clock), .reset(reset_a), .rfsh_en(rfsh_en_a), .wr_req(wr_req_a), .wr_ack(wr_ack_a),
        .rd_start(rd_start_a), .rd_done(rd_done_a), .wr_start(wr_start_a), .wr_done(wr_done_a),
        .rd_ad(rd_ad), .rd_wr(rd_wr), .rd_rd(rd_rd), .rd_cs(rd_cs), .rd_adout(rd_adout),
        .wr_ad(wr_ad), .wr_wr(wr_wr), .wr_rd(wr_rd), .wr_cs(wr_cs), .wr_adout(wr_adout),
        .bus_ad(bad_a), .bus_wr(bwr_a), .bus_rd(brd_a), .bus_cs(bcs_a), .bus_adout(bout_a),
        .grant(grant_a), .busy(busy_a), .timeout_err(tmo_a)
    );

    rtc_bus_arbiter #(.REFRESH_CYCLES(100), .TIMEOUT_CYCLES(300), .GUARD_CYCLES(4)) u_b (
        .clock(clock), .reset(reset_b), .rfsh_en(rfsh_en_b), .wr_req(wr_req_b), .wr_ack(wr_ack_b),
        .rd_start(rd_start_b), .rd_done(rd_done_b), .wr_start(wr_start_b), .wr_done(wr_done_b),
        .rd_ad(rd_ad), .rd_wr(rd_wr), .rd_rd(rd_rd), .rd_cs(rd_cs), .rd_adout(rd_adout),
        .wr_ad(wr_ad), .wr_wr(wr_wr), .wr_rd(wr_rd), .wr_cs(wr_cs), .wr_adout(wr_adout),
        .bus_ad(bad_b), .bus_wr(bwr_b), .bus_rd(brd_b), .bus_cs(bcs_b), .bus_adout(bout_b),
        .grant(grant_b), .busy(busy_b), .timeout_err(tmo_b)
    );

    localparam logic [11:0] BUS_IDLE = {4'b1111, 8'hFF};
    localparam logic [11:0] BUS_RD   = {4'b0100, 8'h5A};
    localparam logic [11:0] BUS_WR   = {4'b1010, 8'hC3};

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to a point 2 time units after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_rd_a(input int budget, output int n);
        n = 0;
        do begin cyc(); #1; n++; end while (!rd_start_a && n < budget);
    endtask

    task automatic wait_wr_a(input int budget, output int n);
        n = 0;
        do begin cyc(); #1; n++; end while (!wr_start_a && n < budget);
    endtask

    task automatic wait_rd_b(input int budget, output int n);
        n = 0;
        do begin cyc(); #1; n++; end while (!rd_start_b && n < budget);
    endtask

    // called in the rd_start cycle of instance A; done after dly cycles, then guard
    task automatic serve_read_a(input int dly);
        check("rd_issue_grant", grant_a, 2'b01);
        check("rd_issue_bus", {bad_a, bwr_a, brd_a, bcs_a, bout_a}, BUS_RD);
        cyc(); #1;
        check("rd_start_pulse", rd_start_a, 1'b0);
        repeat (dly - 2) cyc();
        cyc(); rd_done_a = 1'b1; #1;
        check("rd_grant_at_done", grant_a, 2'b01);
        cyc(); rd_done_a = 1'b0; #1;
        check("guard_grant", grant_a, 2'b00);
        check("guard_bus", {bad_a, bwr_a, brd_a, bcs_a, bout_a}, BUS_IDLE);
        repeat (3) cyc(); #1;
        check("guard_last_busy", busy_a, 1'b1);
        cyc(); #1;
        check("guard_end_idle", busy_a, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    int n;
    int cnt;

    initial begin
        // reset state
        #13;
        check("rst_grant", grant_a, 2'b00);
        check("rst_bus", {bad_a, bwr_a, brd_a, bcs_a, bout_a}, BUS_IDLE);
        check("rst_flags", {busy_a, rd_start_a, wr_start_a, wr_ack_a, tmo_a}, 5'b0);
        cyc();
        reset_a = 1'b1; reset_b = 1'b1; rfsh_en_a = 1'b1;

        // refresh only
        wait_rd_a(300, n);
        check("rfsh_first_latency", n, 100);
        serve_read_a(10);
        wait_rd_a(300, n);
        check("rfsh_period", n, 85);
        serve_read_a(10);

        // write only
        rfsh_en_a = 1'b0;
        wr_req_a  = 1'b1;
        #1;
        check("idle_bus", {bad_a, bwr_a, brd_a, bcs_a, bout_a}, BUS_IDLE);
        wait_wr_a(20, n);
        check("wr_latency", n, 1);
        check("wr_issue_grant", grant_a, 2'b10);
        check("wr_issue_bus", {bad_a, bwr_a, brd_a, bcs_a, bout_a}, BUS_WR);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(); #1;
            cnt += int'(wr_ack_a) + int'(wr_start_a);
        end
        check("wr_busy_quiet", cnt, 0);
        cyc(); wr_done_a = 1'b1; #1;
        check("wr_ack_at_done", wr_ack_a, 1'b1);
        check("wr_grant_at_done", grant_a, 2'b10);
        cyc(); wr_done_a = 1'b0; wr_req_a = 1'b0; #1;
        check("wr_ack_pulse", wr_ack_a, 1'b0);
        check("wr_guard_bus", {grant_a, bad_a, bwr_a, brd_a, bcs_a, bout_a}, {2'b00, BUS_IDLE});
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            cnt += int'(wr_start_a);
        end
        check("wr_single_start", cnt, 0);

        // contention after reset: last owner = write, so read first
        reset_a = 1'b0;
        cyc();
        reset_a = 1'b1; rfsh_en_a = 1'b1;
        repeat (99) cyc();
        wr_req_a = 1'b1;
        cyc(); #1;
        check("cont_rd_first", {rd_start_a, wr_start_a, grant_a}, 4'b1001);
        serve_read_a(10);
        rfsh_en_a = 1'b0;
        wait_wr_a(20, n);
        check("cont_wr_after_guard", n, 1);
        repeat (2) cyc();
        cyc(); wr_done_a = 1'b1; #1;
        check("cont_wr_ack", wr_ack_a, 1'b1);
        cyc(); wr_done_a = 1'b0; wr_req_a = 1'b0;
        repeat (6) cyc();

        // watchdog
        #1;
        check("wd_err_before", tmo_a, 1'b0);
        wr_req_a = 1'b1;
        wait_wr_a(20, n);
        check("wd_wr_start", n, 1);
        n = 0;
        do begin cyc(); #1; n++; end while (!wr_ack_a && n < 100);
        check("wd_release_cycles", n, 50);
        check("wd_grant_at_release", grant_a, 2'b10);
        cyc(); wr_req_a = 1'b0; #1;
        check("wd_grant_released", grant_a, 2'b00);
        check("wd_err_set", tmo_a, 1'b1);
        repeat (30) cyc(); #1;
        check("wd_err_sticky", tmo_a, 1'b1);
        reset_a = 1'b0; #1;
        check("wd_err_reset", {tmo_a, busy_a}, 2'b00);

        // overrun on instance B
        rfsh_en_b = 1'b1;
        wait_rd_b(300, n);
        check("ovr_first", n, 100);
        repeat (249) cyc();
        cyc(); rd_done_b = 1'b1; #1;
        check("ovr_grant_held", grant_b, 2'b01);
        cyc(); rd_done_b = 1'b0;
        wait_rd_b(100, n);
        check("ovr_extra_read", n, 5);
        repeat (9) cyc();
        cyc(); rd_done_b = 1'b1;
        cyc(); rd_done_b = 1'b0;
        wait_rd_b(200, n);
        check("ovr_single_extra", n, 33);
        check("ovr_no_timeout", tmo_b, 1'b0);

        // reset mid RD_BUSY
        repeat (3) cyc();
        rd_adout = 8'hA5; #1;
        check("busy_bus_follow", {bad_b, bwr_b, brd_b, bcs_b, bout_b}, {4'b0100, 8'hA5});
        reset_b = 1'b0; #1;
        check("async_rst_bus", {bad_b, bwr_b, brd_b, bcs_b, bout_b}, BUS_IDLE);
        check("async_rst_outs", {grant_b, busy_b, rd_start_b, wr_start_b, wr_ack_b, tmo_b}, 7'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
